// File: rtl/stream_xbar_pkg.sv
// Shared helpers for the stream_xbar crossbar: index wrap-around and arbiter pick.
// Optional build macro: STREAM_XBAR_RR_EN selects round-robin instead of fixed priority.
package stream_xbar_pkg;

    // Upper bound on source count handled by the pick function.
    localparam int MAX_SOURCES = 32;

    // Increment an index, wrapping to 0 after count-1.
    function automatic int wrap_inc(input int idx, input int count);
        int result;
        if (idx >= count - 1) begin
            result = 0;
        end else begin
            result = idx + 1;
        end
        return result;
    endfunction

    // Lowest requester at or above ptr; otherwise lowest requester overall.
    // Returns -1 when nothing requests. ptr = 0 degenerates to fixed priority.
    function automatic int arb_pick(input logic [MAX_SOURCES-1:0] req,
                                    input int count, input int ptr);
        int first_any;
        int first_ptr;
        first_any = -1;
        first_ptr = -1;
        for (int i = 0; i < MAX_SOURCES; i++) begin
            if (i < count && req[i]) begin
                if (first_any < 0) begin
                    first_any = i;
                end
                if (i >= ptr && first_ptr < 0) begin
                    first_ptr = i;
                end
            end
        end
        return (first_ptr >= 0) ? first_ptr : first_any;
    endfunction

endpackage

// File: rtl/stream_xbar_arb.sv
// Per-master packet arbiter: picks a source when idle and holds it until the
// last beat of its packet is accepted. STREAM_XBAR_RR_EN adds a round-robin pointer.
module stream_xbar_arb
    import stream_xbar_pkg::*;
#(
    parameter  int S_DATA_COUNT = 2,
    localparam int T_ID_WIDTH   = $clog2(S_DATA_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [S_DATA_COUNT-1:0] req,
    input  logic                    sink_ready,
    input  logic                    beat_last,
    output logic [T_ID_WIDTH-1:0]   grant,
    output logic                    valid
);

    logic                  locked_reg;
    logic                  locked_next;
    logic [T_ID_WIDTH-1:0] owner_reg;
    logic [T_ID_WIDTH-1:0] owner_next;
`ifdef STREAM_XBAR_RR_EN
    logic [T_ID_WIDTH-1:0] rr_ptr_reg;
    logic [T_ID_WIDTH-1:0] rr_ptr_next;
`endif
    int pick_idx;
    int ptr_val;

    // Grant selection: owner while locked, arbiter pick while idle; silent in reset.
    always_comb begin
        grant = '0;
        valid = 1'b0;
`ifdef STREAM_XBAR_RR_EN
        ptr_val = int'(rr_ptr_reg);
`else
        ptr_val = 0;
`endif
        pick_idx = arb_pick(MAX_SOURCES'(req), S_DATA_COUNT, ptr_val);
        if (locked_reg) begin
            grant = owner_reg;
            valid = req[owner_reg];
        end else begin
            if (pick_idx >= 0) begin
                grant = T_ID_WIDTH'(pick_idx);
            end
            valid = |req;
        end
        if (rst) begin
            valid = 1'b0;
        end
    end

    // Next-state: lock on a non-last accepted beat, release on the last one.
    always_comb begin
        locked_next = locked_reg;
        owner_next  = owner_reg;
`ifdef STREAM_XBAR_RR_EN
        rr_ptr_next = rr_ptr_reg;
`endif
        if (valid && sink_ready) begin
            if (beat_last) begin
                locked_next = 1'b0;
`ifdef STREAM_XBAR_RR_EN
                rr_ptr_next = T_ID_WIDTH'(wrap_inc(int'(grant), S_DATA_COUNT));
`endif
            end else begin
                locked_next = 1'b1;
                owner_next  = grant;
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_reg <= 1'b0;
            owner_reg  <= '0;
`ifdef STREAM_XBAR_RR_EN
            rr_ptr_reg <= '0;
`endif
        end else begin
            locked_reg <= locked_next;
            owner_reg  <= owner_next;
`ifdef STREAM_XBAR_RR_EN
            rr_ptr_reg <= rr_ptr_next;
`endif
        end
    end

endmodule

// File: rtl/stream_xbar.sv
// S-source by M-sink streaming crossbar with packet-granular arbitration.
// Combinational datapath; only arbitration state is registered.
// Optional build macro: STREAM_XBAR_RR_EN (round-robin; otherwise fixed priority).
module stream_xbar
    import stream_xbar_pkg::*;
#(
    parameter  int T_DATA_WIDTH = 8,
    parameter  int S_DATA_COUNT = 2,
    parameter  int M_DATA_COUNT = 3,
    localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT),
    localparam int T_ID_WIDTH   = $clog2(S_DATA_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [T_DATA_WIDTH-1:0] s_data_i  [S_DATA_COUNT],
    input  logic [T_DEST_WIDTH-1:0] s_dest_i  [S_DATA_COUNT],
    input  logic [S_DATA_COUNT-1:0] s_last_i,
    input  logic [S_DATA_COUNT-1:0] s_valid_i,
    output logic [S_DATA_COUNT-1:0] s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o  [M_DATA_COUNT],
    output logic [T_ID_WIDTH-1:0]   m_id_o    [M_DATA_COUNT],
    output logic [M_DATA_COUNT-1:0] m_last_o,
    output logic [M_DATA_COUNT-1:0] m_valid_o,
    input  logic [M_DATA_COUNT-1:0] m_ready_i
);

    logic [S_DATA_COUNT-1:0] req_by_m  [M_DATA_COUNT];
    logic [T_ID_WIDTH-1:0]   grant_arr [M_DATA_COUNT];
    logic [M_DATA_COUNT-1:0] valid_vec;

    // Request decode: a source requests only the master its dest names.
    always_comb begin
        for (int m = 0; m < M_DATA_COUNT; m++) begin
            req_by_m[m] = '0;
            for (int s = 0; s < S_DATA_COUNT; s++) begin
                req_by_m[m][s] = s_valid_i[s] && (s_dest_i[s] == T_DEST_WIDTH'(m));
            end
        end
    end

    generate
        for (genvar gi = 0; gi < M_DATA_COUNT; gi++) begin : g_arb
            stream_xbar_arb #(
                .S_DATA_COUNT(S_DATA_COUNT)
            ) u_arb (
                .clk        (clk),
                .rst        (rst),
                .req        (req_by_m[gi]),
                .sink_ready (m_ready_i[gi]),
                .beat_last  (m_last_o[gi]),
                .grant      (grant_arr[gi]),
                .valid      (valid_vec[gi])
            );
        end
    endgenerate

    assign m_valid_o = valid_vec;

    // Output mux: forward the granted source, zeros when not valid.
    always_comb begin
        m_last_o = '0;
        for (int m = 0; m < M_DATA_COUNT; m++) begin
            m_data_o[m] = '0;
            m_id_o[m]   = '0;
            if (valid_vec[m]) begin
                m_data_o[m] = s_data_i[grant_arr[m]];
                m_id_o[m]   = grant_arr[m];
                m_last_o[m] = s_last_i[grant_arr[m]];
            end
        end
    end

    // Source ready: OR over masters of (granted to this source and sink ready).
    always_comb begin
        s_ready_o = '0;
        for (int s = 0; s < S_DATA_COUNT; s++) begin
            for (int m = 0; m < M_DATA_COUNT; m++) begin
                if (valid_vec[m] && m_ready_i[m] && req_by_m[m][s] &&
                    grant_arr[m] == T_ID_WIDTH'(s)) begin
                    s_ready_o[s] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_xbar.sv
// Directed bench for stream_xbar (T_DATA_WIDTH=4, S=2, M=2) with hand-computed expectations.
module tb_stream_xbar;

    localparam int DW = 4;
    localparam int S  = 2;
    localparam int M  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data  [S];
    logic [0:0]    s_dest  [S];
    logic [S-1:0]  s_last;
    logic [S-1:0]  s_valid;
    logic [S-1:0]  s_ready;
    logic [DW-1:0] m_data  [M];
    logic [0:0]    m_id    [M];
    logic [M-1:0]  m_last;
    logic [M-1:0]  m_valid;
    logic [M-1:0]  m_ready;

    int n_vec = 0;
    int n_bad = 0;

    stream_xbar #(
        .T_DATA_WIDTH(DW),
        .S_DATA_COUNT(S),
        .M_DATA_COUNT(M)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data),
        .s_dest_i  (s_dest),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_id_o    (m_id),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic v, input int d, input int data, input logic l);
        s_valid[s] = v;
        s_dest[s]  = 1'(d);
        s_data[s]  = DW'(data);
        s_last[s]  = l;
    endtask

    task automatic idle_src();
        set_src(0, 1'b0, 0, 0, 1'b0);
        set_src(1, 1'b0, 0, 0, 1'b0);
    endtask

    // Compare one master port and the source ready vector after inputs settle.
    task automatic exp_m(input string tag, input int m, input logic v, input int data,
                         input int id, input logic l, input int rdy);
        #1;
        $display("%s: m%0d valid=%0b data=%0h id=%0d last=%0b s_ready=%0b",
                 tag, m, m_valid[m], m_data[m], m_id[m], m_last[m], s_ready);
        check({tag, ".valid"}, 32'(m_valid[m]), 32'(v));
        check({tag, ".data"},  32'(m_data[m]),  32'(data));
        check({tag, ".id"},    32'(m_id[m]),    32'(id));
        check({tag, ".last"},  32'(m_last[m]),  32'(l));
        check({tag, ".ready"}, 32'(s_ready),    32'(rdy));
    endtask

    initial begin
        rst = 1'b1;
        m_ready = '1;
        idle_src();
        // Reset state: everything quiet even with a request pending.
        set_src(0, 1'b1, 0, 3, 1'b0);
        exp_m("rst0", 0, 1'b0, 0, 0, 1'b0, 0);
        tick();
        tick();
        rst = 1'b0;
        idle_src();
        exp_m("idle", 0, 1'b0, 0, 0, 1'b0, 0);
        check("idle.m1valid", 32'(m_valid[1]), 32'd0);

        // 1. Contention on m0: src0 A,B(last) while src1 holds C.
        set_src(0, 1'b1, 0, 4'hA, 1'b0);
        set_src(1, 1'b1, 0, 4'hC, 1'b0);
        exp_m("c1.A", 0, 1'b1, 4'hA, 0, 1'b0, 2'b01);
        check("c1.m1valid", 32'(m_valid[1]), 32'd0);
        tick();
        set_src(0, 1'b1, 0, 4'hB, 1'b1);
        exp_m("c1.B", 0, 1'b1, 4'hB, 0, 1'b1, 2'b01);
        tick();
        set_src(0, 1'b0, 0, 0, 1'b0);
        exp_m("c1.C0", 0, 1'b1, 4'hC, 1, 1'b0, 2'b10);
        tick();
        exp_m("c1.C1", 0, 1'b1, 4'hC, 1, 1'b0, 2'b10);
        tick();
        set_src(1, 1'b1, 0, 4'hD, 1'b1);
        exp_m("c1.D", 0, 1'b1, 4'hD, 1, 1'b1, 2'b10);
        tick();
        idle_src();

        // 2. Parallel masters: src0 -> m1, src1 -> m0 in the same cycles.
        set_src(0, 1'b1, 1, 4'hE, 1'b0);
        set_src(1, 1'b1, 0, 4'h8, 1'b0);
        exp_m("p2.E", 1, 1'b1, 4'hE, 0, 1'b0, 2'b11);
        exp_m("p2.8", 0, 1'b1, 4'h8, 1, 1'b0, 2'b11);
        tick();
        set_src(0, 1'b1, 1, 4'hF, 1'b1);
        set_src(1, 1'b1, 0, 4'h9, 1'b1);
        exp_m("p2.F", 1, 1'b1, 4'hF, 0, 1'b1, 2'b11);
        exp_m("p2.9", 0, 1'b1, 4'h9, 1, 1'b1, 2'b11);
        tick();
        idle_src();

        // 3. Backpressure mid-packet on m0.
        set_src(0, 1'b1, 0, 4'h1, 1'b0);
        exp_m("b3.1", 0, 1'b1, 4'h1, 0, 1'b0, 2'b01);
        tick();
        set_src(0, 1'b1, 0, 4'h2, 1'b0);
        m_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_m($sformatf("b3.hold%0d", i), 0, 1'b1, 4'h2, 0, 1'b0, 2'b00);
            tick();
        end
        m_ready[0] = 1'b1;
        exp_m("b3.2", 0, 1'b1, 4'h2, 0, 1'b0, 2'b01);
        tick();
        set_src(0, 1'b1, 0, 4'h3, 1'b1);
        exp_m("b3.3", 0, 1'b1, 4'h3, 0, 1'b1, 2'b01);
        tick();
        idle_src();

        // 4. Fairness: both sources stream single-beat packets to m0 from a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_src(0, 1'b1, 0, 4'h5, 1'b1);
        set_src(1, 1'b1, 0, 4'h6, 1'b1);
        for (int i = 0; i < 4; i++) begin
`ifdef STREAM_XBAR_RR_EN
            if (i % 2 == 0) begin
                exp_m($sformatf("f4.%0d", i), 0, 1'b1, 4'h5, 0, 1'b1, 2'b01);
            end else begin
                exp_m($sformatf("f4.%0d", i), 0, 1'b1, 4'h6, 1, 1'b1, 2'b10);
            end
`else
            exp_m($sformatf("f4.%0d", i), 0, 1'b1, 4'h5, 0, 1'b1, 2'b01);
`endif
            tick();
        end
        idle_src();

        // 5. Owner stalls mid-packet; src1 must wait for the owner's last beat.
        set_src(0, 1'b1, 0, 4'h7, 1'b0);
        set_src(1, 1'b1, 0, 4'h6, 1'b1);
        exp_m("s5.7", 0, 1'b1, 4'h7, 0, 1'b0, 2'b01);
        tick();
        set_src(0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp_m($sformatf("s5.stall%0d", i), 0, 1'b0, 0, 0, 1'b0, 2'b00);
            tick();
        end
        set_src(0, 1'b1, 0, 4'h8, 1'b1);
        exp_m("s5.8", 0, 1'b1, 4'h8, 0, 1'b1, 2'b01);
        tick();
        set_src(0, 1'b0, 0, 0, 1'b0);
        exp_m("s5.6", 0, 1'b1, 4'h6, 1, 1'b1, 2'b10);
        tick();
        idle_src();

        // 6. Reset mid-packet drops the lock.
        set_src(0, 1'b1, 0, 4'h3, 1'b0);
        exp_m("r6.3", 0, 1'b1, 4'h3, 0, 1'b0, 2'b01);
        tick();
        set_src(0, 1'b1, 0, 4'h4, 1'b0);
        set_src(1, 1'b1, 0, 4'h9, 1'b0);
        rst = 1'b1;
        exp_m("r6.rst", 0, 1'b0, 0, 0, 1'b0, 2'b00);
        tick();
        rst = 1'b0;
        set_src(0, 1'b0, 0, 0, 1'b0);
        exp_m("r6.new", 0, 1'b1, 4'h9, 1, 1'b0, 2'b10);
        tick();
        idle_src();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_xbar.md
Name: stream_xbar

Overview:
Parameterised S-source by M-sink streaming crossbar with packet-granular arbitration. Each source beat carries data, a destination index and a last flag. Each master (sink) port arbitrates independently among the sources addressing it and holds the grant until the granted packet's last beat is accepted. Sits between stream producers and consumers as a zero-latency combinational datapath with registered arbitration state.

Parameters:
T_DATA_WIDTH, 8, data beat width in bits (>=1)
S_DATA_COUNT, 2, number of source ports (>=2)
M_DATA_COUNT, 3, number of master ports (>=2)
T_DEST_WIDTH, $clog2(M_DATA_COUNT), derived localparam, destination field width
T_ID_WIDTH, $clog2(S_DATA_COUNT), derived localparam, source id width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
s_data_i  in  [T_DATA_WIDTH-1:0] x S_DATA_COUNT (unpacked)  source data
s_dest_i  in  [T_DEST_WIDTH-1:0] x S_DATA_COUNT  target master index
s_last_i  in  [S_DATA_COUNT-1:0]  last beat of packet
s_valid_i  in  [S_DATA_COUNT-1:0]  source beat valid
s_ready_o  out  [S_DATA_COUNT-1:0]  source beat accepted when valid & ready
m_data_o  out  [T_DATA_WIDTH-1:0] x M_DATA_COUNT  forwarded data
m_id_o  out  [T_ID_WIDTH-1:0] x M_DATA_COUNT  index of granted source
m_last_o  out  [M_DATA_COUNT-1:0]  forwarded last
m_valid_o  out  [M_DATA_COUNT-1:0]  master beat valid
m_ready_i  in  [M_DATA_COUNT-1:0]  master sink ready

Behaviour:
- Request: req[m][s] = s_valid_i[s] & (s_dest_i[s] == m). A dest >= M_DATA_COUNT requests nothing; s_ready_o for that source is 0.
- Per master m, registered state: locked[m] (1 bit), owner[m] (T_ID_WIDTH bits), rr_ptr[m] (T_ID_WIDTH bits).
- Idle (locked=0): grant = arbiter pick among req[m][*]. m_valid_o[m] = |req[m].
- Locked: grant = owner. m_valid_o[m] = req[m][owner]. No other source is served. A stall or a dest change by the owner only produces m_valid_o=0 and does not release the lock.
- Master outputs:
  - m_data_o/m_last_o = granted source's data/last.
  - m_id_o = grant index.
  - When m_valid_o=0, all of these are driven to 0.
- Source ready: s_ready_o[s] = m_ready_i[s_dest_i[s]] & (grant of that master == s) & req valid. This is combinational, zero latency, and ready may depend on valid.
- Handshake on master m (m_valid_o & m_ready_i):
  - last=0: locked<=1, owner<=grant.
  - last=1: locked<=0; rr_ptr<=grant+1, wrapping to 0 after S_DATA_COUNT-1.
- Single-beat packets never lock.
- Round-robin: in the idle state, the lowest index s >= rr_ptr with req wins. If none, the lowest index overall with req wins.
- Different masters operate fully in parallel. One source drives at most one master per cycle, selected by its dest.
- Reset (rst=1 at clock edge): locked=0, owner=0, rr_ptr=0. While rst is high, m_valid_o=0, s_ready_o=0, and all other master outputs are 0. Reset mid-packet drops the lock; the next packet arbitrates fresh.
- No buffering; throughput is 1 beat/cycle/master.

Optional Feature:
STREAM_XBAR_RR_EN:
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, lowest source index wins when idle; rr_ptr is not implemented.
- Packet locking is identical in both builds.

Decomposition:
- Package stream_xbar_pkg: helper function for the wrap-around increment of a T_ID_WIDTH index, and the arbiter pick function.
- One sub-module, stream_xbar_arb: per-master lock and arbiter, instantiated M_DATA_COUNT times in a generate loop.
- The top module does request decode, output muxing and s_ready_o OR-reduction.

Test Plan:
1. Contention, T_DATA_WIDTH=4, S=2, M=2, RR build:
   - Stimulus: after reset, src0 sends A, B(last) to m0 while src1 holds C to m0; src1 then sends C, C, D(last).
   - Required: m0 carries A,B with id0, then C,C,D with id1; s_ready_o[1]=0 during src0's packet; no interleaving.
2. Parallel masters: src0 sends E, F(last) to m1 while src1 sends 8, 9(last) to m0 in the same cycles → both delivered each cycle, id0 on m1, id1 on m0, both sources ready=1.
3. Backpressure: m_ready_i[0]=0 for 3 cycles mid-packet → m_data_o held, s_ready_o=0, no beat lost or duplicated; resumes on ready.
4. Round-robin fairness: both sources continuously send single-beat packets to m0 → ids alternate 0,1,0,1. In a build without STREAM_XBAR_RR_EN → id stays 0.
5. Source stall mid-packet: owner drops valid for 2 cycles while the other source requests → m_valid_o=0 and the other source is not granted until the owner's last beat.
6. Reset mid-packet: assert rst after the first beat → outputs 0; after release, a new request from src1 is granted immediately.
